// File: rtl/sram_ctrl_pkg.sv
// Shared widths, FSM state encoding and request payload for the SRAM access controller.
// The burst feature is selected with SRAM_BURST_EN.
package sram_ctrl_pkg;

  localparam int unsigned ADDR_BITS = 16;
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned LEN_BITS  = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    READ     = 2'd2,
    RSP_WAIT = 2'd3
  } sram_ctrl_state_t;

  typedef struct packed {
    logic                 write;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
    logic [LEN_BITS-1:0]  len;
  } sram_req_t;

endpackage

// File: rtl/sram_access_ctrl_if.sv
// Client request/response channels plus the SRAM pin bundle seen by the controller.
// req_len/rsp_last exist only when SRAM_BURST_EN is defined.
interface sram_access_ctrl_if;
  import sram_ctrl_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [ADDR_BITS-1:0] req_addr;
  logic [DATA_BITS-1:0] req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DATA_BITS-1:0] rsp_rdata;
  logic                 sram_read_enable;
  logic                 sram_write_enable;
  logic [ADDR_BITS-1:0] sram_address;
  logic [DATA_BITS-1:0] sram_write_data;
  logic [DATA_BITS-1:0] sram_read_data;
`ifdef SRAM_BURST_EN
  logic [LEN_BITS-1:0]  req_len;
  logic                 rsp_last;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_len, rsp_ready, sram_read_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_last,
           sram_read_enable, sram_write_enable, sram_address, sram_write_data
  );
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_len, rsp_ready, sram_read_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last,
           sram_read_enable, sram_write_enable, sram_address, sram_write_data
  );
`else
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, sram_read_data,
    output req_ready, rsp_valid, rsp_rdata,
           sram_read_enable, sram_write_enable, sram_address, sram_write_data
  );
  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, sram_read_data,
    input  req_ready, rsp_valid, rsp_rdata,
           sram_read_enable, sram_write_enable, sram_address, sram_write_data
  );
`endif
endinterface

// File: rtl/sram_burst_counter.sv
// Burst address generator: wrapping word-address incrementer plus beats-remaining counter.
// Only built when SRAM_BURST_EN is defined.
`ifdef SRAM_BURST_EN
module sram_burst_counter
  import sram_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 load_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [LEN_BITS-1:0]  len_i,
  input  logic                 adv_i,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic                 last_c_o
);

  logic [ADDR_BITS-1:0] addr_q;
  logic [LEN_BITS-1:0]  rem_q;

  // Address wraps naturally at 2^ADDR_BITS.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else if (load_i) begin
      addr_q <= addr_i;
      rem_q  <= len_i;
    end else if (adv_i) begin
      addr_q <= addr_q + ADDR_BITS'(1);
      rem_q  <= rem_q - LEN_BITS'(1);
    end
  end

  assign addr_o   = addr_q;
  assign last_c_o = (rem_q == '0);

endmodule
`endif

// File: rtl/sram_access_ctrl.sv
// Turns a valid/ready request stream into single-cycle SRAM accesses and returns read data.
// Define SRAM_BURST_EN for pipelined multi-beat reads driven by sram_burst_counter.
module sram_access_ctrl
  import sram_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  sram_access_ctrl_if.slave bus,
  output logic              busy
);

  sram_ctrl_state_t     state_q, state_d;
  sram_req_t            req_c;
  logic                 accept_c, issue_c, last_c;
  logic [ADDR_BITS-1:0] addr_c;
  logic                 req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 we_q, we_d;
  logic                 busy_q, busy_d;
  logic [DATA_BITS-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;

  always_comb begin
    req_c.write = bus.req_write;
    req_c.addr  = bus.req_addr;
    req_c.wdata = bus.req_wdata;
`ifdef SRAM_BURST_EN
    req_c.len   = bus.req_len;
`else
    req_c.len   = '0;
`endif
  end

  assign accept_c = bus.req_valid && req_ready_q;

`ifdef SRAM_BURST_EN
  logic rsp_last_q, rsp_last_d;
  logic adv_c;

  // A beat is read only when its data has somewhere to land this edge.
  assign issue_c = (state_q == READ) && (!rsp_valid_q || bus.rsp_ready);
  assign adv_c   = issue_c && !last_c;

  sram_burst_counter u_burst_counter (
    .clk      (clk),
    .n_rst    (n_rst),
    .load_i   (accept_c),
    .addr_i   (req_c.addr),
    .len_i    (req_c.len),
    .adv_i    (adv_c),
    .addr_o   (addr_c),
    .last_c_o (last_c)
  );
`else
  logic                 re_q, re_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;

  // len is tied to zero in this build, so every read is its own last beat.
  assign issue_c = re_q;
  assign last_c  = (req_c.len == '0);
  assign addr_c  = addr_q;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept_c) state_d = req_c.write ? WRITE : READ;
      WRITE:    state_d = IDLE;
      READ:     if (issue_c && last_c) state_d = RSP_WAIT;
      RSP_WAIT: if (bus.rsp_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Next values of every registered output.
  always_comb begin
    rsp_valid_d = rsp_valid_q && !bus.rsp_ready;
    rsp_rdata_d = rsp_rdata_q;
    we_d        = 1'b0;
    wdata_d     = wdata_q;
`ifdef SRAM_BURST_EN
    rsp_last_d  = rsp_valid_d ? rsp_last_q : 1'b0;
`else
    re_d        = accept_c && !req_c.write;
    addr_d      = accept_c ? req_c.addr : addr_q;
`endif
    if (issue_c) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = bus.sram_read_data;
`ifdef SRAM_BURST_EN
      rsp_last_d  = last_c;
`endif
    end
    if (accept_c && req_c.write) begin
      we_d    = 1'b1;
      wdata_d = req_c.wdata;
    end
    req_ready_d = (state_d == IDLE) && !rsp_valid_d;
    busy_d      = (state_d != IDLE) || rsp_valid_d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
`ifdef SRAM_BURST_EN
      rsp_last_q  <= 1'b0;
`else
      re_q        <= 1'b0;
      addr_q      <= '0;
`endif
    end else begin
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
`ifdef SRAM_BURST_EN
      rsp_last_q  <= rsp_last_d;
`else
      re_q        <= re_d;
      addr_q      <= addr_d;
`endif
    end
  end

  assign bus.req_ready         = req_ready_q;
  assign bus.rsp_valid         = rsp_valid_q;
  assign bus.rsp_rdata         = rsp_rdata_q;
  assign bus.sram_write_enable = we_q;
  assign bus.sram_write_data   = wdata_q;
  assign bus.sram_address      = addr_c;
  assign busy                  = busy_q;
`ifdef SRAM_BURST_EN
  assign bus.sram_read_enable  = issue_c;
  assign bus.rsp_last          = rsp_last_q;
`else
  assign bus.sram_read_enable  = re_q;
`endif

endmodule
